// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage. Owns the PC, issues word fetches with a credit
// limit, buffers responses in a small queue and drives the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(FQ_DEPTH);

  logic [31:0]      fetch_pc;

  logic [31:0]      q_pc    [FQ_DEPTH];
  logic [31:0]      q_instr [FQ_DEPTH];
  logic [PTR_W-1:0] q_rd;
  logic [PTR_W-1:0] q_wr;
  logic [CNT_W-1:0] q_cnt;

  logic [31:0]      pf_pc [FQ_DEPTH];
  logic [PTR_W-1:0] pf_rd;
  logic [PTR_W-1:0] pf_wr;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;

  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             rsp_drop;
  logic             q_push;
  logic             q_pop;
  logic [31:0]      redirect_target;

  assign credit_used     = {1'b0, outstanding} + {1'b0, q_cnt};
  assign imem_req_valid  = !rst && !redirect_valid && (credit_used < CREDIT);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_drop        = imem_rsp_valid && (drop_cnt != '0);
  assign q_push          = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign q_pop           = !redirect_valid && !flush && !stall && (q_cnt != '0);
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // PC, outstanding-request FIFO pointers and drop accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pf_rd       <= '0;
      pf_wr       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire) begin
        pf_wr <= pf_wr + PTR_W'(1);
      end
      if (imem_rsp_valid) begin
        pf_rd <= pf_rd + PTR_W'(1);
      end
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      // Every request still in flight at a redirect is stale, including ones
      // already marked by an earlier redirect, so the new drop count is simply
      // what remains outstanding after this cycle's response.
      if (redirect_valid) begin
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      end else if (rsp_drop) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  // PC FIFO storage for outstanding requests
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pf_pc[pf_wr] <= fetch_pc;
    end
  end

  // Fetch queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else if (redirect_valid) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) begin
        q_wr <= q_wr + PTR_W'(1);
      end
      if (q_pop) begin
        q_rd <= q_rd + PTR_W'(1);
      end
      q_cnt <= q_cnt + CNT_W'(q_push) - CNT_W'(q_pop);
    end
  end

  // Fetch queue storage
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_pc[q_wr]    <= pf_pc[pf_rd];
      q_instr[q_wr] <= imem_rsp_data;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (redirect_valid || flush) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (q_cnt != '0) begin
        id_pc    <= q_pc[q_rd];
        id_instr <= q_instr[q_rd];
        id_valid <= 1'b1;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with an in-order memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  int passed = 0;
  int total  = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .flush(flush),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int edge_n; } dl_t;

  mreq_t       mq[$];
  dl_t         dlog[$];
  logic [31:0] acc_log[$];
  int          acc_edge[$];
  int          lat = 1;
  int          cyc = 0;
  logic        acc_pend = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        stall_s = 1'b0;

  // Memory model: accepts at an edge, answers in order lat edges later
  always @(posedge clk) begin
    logic        acc_now;
    logic [31:0] addr_now;
    cyc++;
    stall_s  = stall;
    acc_now  = acc_pend;
    addr_now = acc_addr;
    #1;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (acc_now) begin
        mq.push_back('{addr_now, cyc + lat});
        acc_log.push_back(addr_now);
        acc_edge.push_back(cyc);
      end
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Mid-cycle sampling: pending accept and fresh IF/ID deliveries
  always @(negedge clk) begin
    acc_pend = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (!rst && id_valid && !stall_s) dlog.push_back('{id_pc, id_instr, cyc});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = rdy;
    tick(); tick();
    dlog.delete(); acc_log.delete(); acc_edge.delete();
  endtask

  task automatic test_reset();
    lat = 1;
    do_reset(1'b1);
    total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %0h want 0", id_valid); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 00000000", id_pc); else passed++;
    total++; if (id_instr !== 32'h13) $display("FAIL reset_id_instr: got %h want 00000013", id_instr); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0h want 0", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); else passed++;
  endtask

  task automatic test_stream();
    rst = 1'b0;
    run(14);
    total++; if (acc_log.size() < 6) $display("FAIL stream_acc_count: got %0d want >=6", acc_log.size()); else passed++;
    for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
      total++; if (acc_log[i] !== 32'(4 * i)) $display("FAIL stream_req_addr[%0d]: got %h want %h", i, acc_log[i], 32'(4 * i)); else passed++;
    end
    total++; if (dlog.size() < 6) $display("FAIL stream_id_count: got %0d want >=6", dlog.size()); else passed++;
    for (int i = 0; i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'(4 * i)) $display("FAIL stream_id_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'(4 * i)); else passed++;
      total++; if (dlog[i].instr !== instr_of(32'(4 * i))) $display("FAIL stream_id_instr[%0d]: got %h want %h", i, dlog[i].instr, instr_of(32'(4 * i))); else passed++;
    end
    if (dlog.size() >= 2 && acc_edge.size() >= 1) begin
      total++; if (dlog[0].edge_n !== acc_edge[0] + 2) $display("FAIL stream_first_latency: got edge %0d want %0d", dlog[0].edge_n, acc_edge[0] + 2); else passed++;
      total++; if (dlog[1].edge_n !== dlog[0].edge_n + 1) $display("FAIL stream_second_consecutive: got edge %0d want %0d", dlog[1].edge_n, dlog[0].edge_n + 1); else passed++;
    end
  endtask

  task automatic test_stall();
    int n;
    int w = 0;
    logic [31:0] exp_pc;
    while (id_valid !== 1'b1 && w < 20) begin tick(); w++; end
    total++; if (id_valid !== 1'b1) $display("FAIL stall_wait_valid: got %0h want 1", id_valid); else passed++;
    n = dlog.size();
    exp_pc = 32'(4 * n);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (id_pc !== exp_pc) $display("FAIL stall_hold_pc[%0d]: got %h want %h", k, id_pc, exp_pc); else passed++;
      total++; if (id_instr !== instr_of(exp_pc)) $display("FAIL stall_hold_instr[%0d]: got %h want %h", k, id_instr, instr_of(exp_pc)); else passed++;
      total++; if (id_valid !== 1'b1) $display("FAIL stall_hold_valid[%0d]: got %0h want 1", k, id_valid); else passed++;
      if (k >= 1) begin
        total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_credit_full[%0d]: got %0h want 0", k, imem_req_valid); else passed++;
      end
    end
    stall = 1'b0;
    run(12);
    total++; if (dlog.size() < n + 5) $display("FAIL stall_resume_count: got %0d want >=%0d", dlog.size(), n + 5); else passed++;
    for (int i = 0; i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'(4 * i)) $display("FAIL stall_seq_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_flush();
    int n;
    int w = 0;
    lat = 1;
    do_reset(1'b1);
    rst = 1'b0;
    run(6);
    while (id_valid !== 1'b1 && w < 20) begin tick(); w++; end
    total++; if (id_valid !== 1'b1) $display("FAIL flush_wait_valid: got %0h want 1", id_valid); else passed++;
    n = dlog.size();
    stall = 1'b1;
    run(3);
    stall = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (id_valid !== 1'b0) $display("FAIL flush_kill: got %0h want 0", id_valid); else passed++;
    tick();
    total++; if (id_valid !== 1'b1) $display("FAIL flush_next_valid: got %0h want 1", id_valid); else passed++;
    total++; if (id_pc !== 32'(4 * (n + 1))) $display("FAIL flush_next_pc: got %h want %h", id_pc, 32'(4 * (n + 1))); else passed++;
    total++; if (id_instr !== instr_of(32'(4 * (n + 1)))) $display("FAIL flush_next_instr: got %h want %h", id_instr, instr_of(32'(4 * (n + 1)))); else passed++;
    run(8);
    for (int i = 0; i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'(4 * i)) $display("FAIL flush_seq_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_redirect();
    int w = 0;
    lat = 3;
    do_reset(1'b1);
    rst = 1'b0;
    while (mq.size() != 2 && w < 10) begin tick(); w++; end
    total++; if (mq.size() != 2) $display("FAIL redir_wait_outstanding: got %0d want 2", mq.size()); else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req_blocked: got %0h want 0", imem_req_valid); else passed++;
    tick();
    redirect_valid = 1'b0;
    total++; if (dut.drop_cnt !== 2'd2) $display("FAIL redir_drop_cnt: got %0d want 2", dut.drop_cnt); else passed++;
    run(25);
    total++; if (dlog.size() < 3) $display("FAIL redir_id_count: got %0d want >=3", dlog.size()); else passed++;
    for (int i = 0; i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'h100 + 32'(4 * i)) $display("FAIL redir_id_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'h100 + 32'(4 * i)); else passed++;
    end
    total++; if (acc_log.size() < 3) $display("FAIL redir_acc_count: got %0d want >=3", acc_log.size()); else passed++;
    if (acc_log.size() >= 3) begin
      total++; if (acc_log[2] !== 32'h100) $display("FAIL redir_first_target_req: got %h want 00000100", acc_log[2]); else passed++;
    end
  endtask

  task automatic test_redirect_rsp();
    int w = 0;
    lat = 2;
    do_reset(1'b1);
    rst = 1'b0;
    while (imem_rsp_valid !== 1'b1 && w < 10) begin tick(); w++; end
    total++; if (imem_rsp_valid !== 1'b1) $display("FAIL redir_rsp_wait: got %0h want 1", imem_rsp_valid); else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0240;
    tick();
    redirect_valid = 1'b0;
    total++; if (dut.drop_cnt !== 2'd1) $display("FAIL redir_rsp_drop_cnt: got %0d want 1", dut.drop_cnt); else passed++;
    total++; if (dut.outstanding !== 2'd1) $display("FAIL redir_rsp_outstanding: got %0d want 1", dut.outstanding); else passed++;
    run(20);
    total++; if (dlog.size() < 3) $display("FAIL redir_rsp_id_count: got %0d want >=3", dlog.size()); else passed++;
    for (int i = 0; i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'h240 + 32'(4 * i)) $display("FAIL redir_rsp_id_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'h240 + 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_ready_low();
    lat = 1;
    do_reset(1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (imem_req_valid !== 1'b1) $display("FAIL rdy_low_valid[%0d]: got %0h want 1", k, imem_req_valid); else passed++;
      total++; if (imem_req_addr !== 32'h0) $display("FAIL rdy_low_addr[%0d]: got %h want 00000000", k, imem_req_addr); else passed++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rdy_low_redir_valid: got %0h want 0", imem_req_valid); else passed++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_addr !== 32'h200) $display("FAIL rdy_low_target_addr: got %h want 00000200", imem_req_addr); else passed++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL rdy_low_target_valid: got %0h want 1", imem_req_valid); else passed++;
    imem_req_ready = 1'b1;
    run(12);
    total++; if (acc_log.size() < 1 || acc_log[0] !== 32'h200) $display("FAIL rdy_low_first_acc: got %h want 00000200", (acc_log.size() > 0) ? acc_log[0] : 32'hxxxx_xxxx); else passed++;
    total++; if (dlog.size() < 2) $display("FAIL rdy_low_id_count: got %0d want >=2", dlog.size()); else passed++;
    for (int i = 0; i < 2 && i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'h200 + 32'(4 * i)) $display("FAIL rdy_low_id_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'h200 + 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    rst = 1'b0;
    tick();
    redirect_valid = 1'b0;
    run(14);
    total++; if (dlog.size() < 4) $display("FAIL wrap_id_count: got %0d want >=4", dlog.size()); else passed++;
    for (int i = 0; i < 4 && i < dlog.size(); i++) begin
      total++; if (dlog[i].pc !== 32'hFFFF_FFF8 + 32'(4 * i)) $display("FAIL wrap_id_pc[%0d]: got %h want %h", i, dlog[i].pc, 32'hFFFF_FFF8 + 32'(4 * i)); else passed++;
    end
    total++; if (acc_log.size() < 3 || acc_log[2] !== 32'h0) $display("FAIL wrap_req_addr2: got %h want 00000000", (acc_log.size() > 2) ? acc_log[2] : 32'hxxxx_xxxx); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_redirect();
    test_redirect_rsp();
    test_ready_low();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
